// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one next-level cache port between two requesters.
// Optional ARB_WATCHDOG_EN aborts an ISSUE that waits TIMEOUT cycles, flagging arb_error.
module cache_arbiter #(
  parameter int ADDRESSWIDTH = 32,
  parameter int DATAWIDTH    = 32,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    r0_request,
  input  logic [1:0]              r0_operation,
  input  logic [ADDRESSWIDTH-1:0] r0_addr,
  input  logic [DATAWIDTH-1:0]    r0_d_in,
  output logic [DATAWIDTH-1:0]    r0_d_out,
  output logic                    r0_valid,
  output logic                    r0_evict,
  input  logic                    r1_request,
  input  logic [1:0]              r1_operation,
  input  logic [ADDRESSWIDTH-1:0] r1_addr,
  input  logic [DATAWIDTH-1:0]    r1_d_in,
  output logic [DATAWIDTH-1:0]    r1_d_out,
  output logic                    r1_valid,
  output logic                    r1_evict,
  output logic                    nl_request,
  output logic [1:0]              nl_operation,
  output logic [ADDRESSWIDTH-1:0] nl_addr,
  output logic [DATAWIDTH-1:0]    nl_d_in,
  input  logic [DATAWIDTH-1:0]    nl_d_out,
  input  logic                    nl_valid,
  input  logic                    nl_evict,
  output logic                    arb_error
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [1:0] OP_NOP = 2'd0;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("cache_arbiter: TIMEOUT must be at least 2");
  end

  state_t                  state_q, state_d;
  logic                    last_q, last_d, owner_q, owner_d, err_q, err_d;
  logic [1:0]              op_q, op_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0]    din_q, din_d, data_q, data_d;
  logic                    grant, win, issue, resp;
  logic [1:0]              win_op;

  assign grant  = state_q == IDLE && !nl_evict && (r0_request || r1_request);
  assign win    = (r0_request && r1_request) ? ~last_q : r1_request;
  assign win_op = win ? r1_operation : r0_operation;

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    err_d   = err_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    data_d  = data_q;
`ifdef ARB_WATCHDOG_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: if (grant) begin
        owner_d = win;
        op_d    = win_op;
        addr_d  = win ? r1_addr : r0_addr;
        din_d   = win ? r1_d_in : r0_d_in;
        data_d  = '0;
        err_d   = 1'b0;
        state_d = win_op == OP_NOP ? RESP : ISSUE;
`ifdef ARB_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      ISSUE: if (nl_valid) begin
        // READ (1) and RFO (3) return data; both have bit 0 set
        data_d  = op_q[0] ? nl_d_out : '0;
        state_d = RESP;
      end
`ifdef ARB_WATCHDOG_EN
      else if (cnt_q == CW'(TIMEOUT - 1)) begin
        data_d  = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + 1'b1;
`endif
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      data_q  <= data_d;
    end

  assign issue        = state_q == ISSUE;
  assign resp         = state_q == RESP;
  assign nl_request   = issue;
  assign nl_operation = issue ? op_q : '0;
  assign nl_addr      = issue ? addr_q : '0;
  assign nl_d_in      = issue ? din_q : '0;
  assign r0_valid     = resp && !owner_q;
  assign r1_valid     = resp && owner_q;
  assign r0_d_out     = r0_valid ? data_q : '0;
  assign r1_d_out     = r1_valid ? data_q : '0;
  assign r0_evict     = nl_evict;
  assign r1_evict     = nl_evict;
`ifdef ARB_WATCHDOG_EN
  assign arb_error    = resp && err_q;
`else
  assign arb_error    = 1'b0;
`endif
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-requester arbiter that shares one next-level cache port between two upper-level caches (e.g. I-cache on port 0, D-cache on port 1). Each request is captured, forwarded to the next level with a request/valid handshake, and answered with a one-cycle valid pulse back to its owner. Grants are round-robin, and the next level's evict line is broadcast to both requesters.

## Interface
Parameters:
- ADDRESSWIDTH, 32, address width on all ports
- DATAWIDTH, 32, data width on all ports
- TIMEOUT, 1024, watchdog limit in cycles (used only with ARB_WATCHDOG_EN; must be ≥2)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately
- r0_request / r1_request  in  1  requester holds high until its valid pulse
- r0_operation / r1_operation  in  2  NOP=0, READ=1, WRITE=2, RFO=3
- r0_addr / r1_addr  in  ADDRESSWIDTH  request address
- r0_d_in / r1_d_in  in  DATAWIDTH  write data
- r0_d_out / r1_d_out  out  DATAWIDTH  read data, meaningful only while the matching valid is high
- r0_valid / r1_valid  out  1  one-cycle completion pulse
- r0_evict / r1_evict  out  1  combinational copy of nl_evict
- nl_request  out  1  request to next level
- nl_operation  out  2  operation to next level
- nl_addr  out  ADDRESSWIDTH  address to next level
- nl_d_in  out  DATAWIDTH  write data to next level
- nl_d_out  in  DATAWIDTH  read data from next level, sampled when nl_valid=1
- nl_valid  in  1  next-level completion
- nl_evict  in  1  next-level eviction interrupt
- arb_error  out  1  watchdog-abort flag, high during the aborted response cycle

## Operation
- Reset values: state IDLE, `last`=1 (port 0 wins the first tie), hold registers 0, every output 0.
- States:
  - IDLE: grant only if nl_evict=0 and at least one request is high.
    - Single requester: it wins.
    - Both requesting: the port ≠ `last` wins.
    - On grant, latch `owner`, operation, address and d_in into hold registers.
    - Granted op is NOP: go to RESP directly.
    - Otherwise: go to ISSUE.
  - ISSUE:
    - Drive nl_request=1; nl_operation, nl_addr and nl_d_in come from the hold registers.
    - nl_valid=1: capture nl_d_out if op is READ or RFO, else capture 0; go to RESP.
    - nl_valid=0: stay in ISSUE.
  - RESP:
    - `owner`'s valid=1 and its d_out = captured data; the other port's outputs stay 0.
    - Update `last`←`owner`; go to IDLE.
- While not granted, every nl_* output is 0 and every r*_d_out is 0.
- Requester inputs are ignored after grant; the hold registers are authoritative.
- A requester that keeps its request high into IDLE after its valid pulse is treated as a new request.
- nl_evict high during ISSUE does not abort the transfer. It only blocks new grants in IDLE.
- Evict broadcast is purely combinational and independent of state.

## Timing
- Minimum latency, with requests sampled at rising edges:
  - Request high in cycle 0 (IDLE).
  - nl_request high in cycle 1.
  - If nl_valid=1 in cycle 1: r_valid high in cycle 2, IDLE in cycle 3.
  - Earliest next nl_request: cycle 4.
- NOP request: request in cycle 0, r_valid in cycle 1, IDLE in cycle 2.
- nl_request stays high continuously from ISSUE entry through the cycle nl_valid is seen, and drops in the RESP cycle.
- Reset asserted mid-ISSUE: nl_request and all valids drop asynchronously, no response is issued, `last`=1. After release the requester must re-present its request.

## Configuration
- ARB_WATCHDOG_EN defined:
  - A counter clears on ISSUE entry and increments each ISSUE cycle with nl_valid=0.
  - If the counter reaches TIMEOUT-1 with nl_valid still 0, go to RESP with captured data 0 and arb_error=1 for that RESP cycle only.
  - Counter width is $clog2(TIMEOUT).
- ARB_WATCHDOG_EN undefined: no counter, ISSUE waits indefinitely, arb_error tied to 0.

## Test plan
- Single READ: r0 READ at addr 0x0000_1040 with nl_valid the cycle after nl_request and nl_d_out=0xDEADBEEF -> nl_addr=0x0000_1040, nl_operation=1, r0_valid one cycle with r0_d_out=0xDEADBEEF, r1_valid stays 0.
- Tie sequence: r0 and r1 request simultaneously and continuously, next level answers immediately -> grant order r0, r1, r0, r1; each grant's nl_request starts exactly 4 cycles after the previous one.
- WRITE/RFO: r1 WRITE, d_in=0x12345678 -> nl_d_in=0x12345678, nl_operation=2, r1_d_out=0 at valid. r1 RFO -> nl_operation=3 and read data returned.
- Evict: nl_evict=1 for 5 cycles while r0 requests -> r0_evict and r1_evict mirror it, no grant during those cycles, grant in the first IDLE cycle after nl_evict falls. Evict mid-ISSUE -> transfer still completes.
- Reset mid-op: assert reset during ISSUE -> nl_request=0 in the same cycle, no r0_valid. After release with both requesting -> r0 granted first.
- Watchdog (ARB_WATCHDOG_EN, TIMEOUT=8): nl_valid never asserted -> nl_request high for 8 cycles, then r0_valid=1, arb_error=1, r0_d_out=0 for one cycle, then IDLE. Without the macro -> still in ISSUE after 100 cycles, arb_error=0.
